// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result-path sequencer and the result mux:
//   - opcode encodings (OP_CMP..OP_MUL), 5..7 are illegal
//   - sequencer state enum
//   - one-hot select bit indices, shared with the result mux
//   - helpers: opcode legality and opcode-to-select decode
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SEL_W = 5;

    localparam logic [OP_W-1:0] OP_CMP = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL = 3'd4;

    // Bit positions inside the select vector driven to the result mux
    localparam int unsigned SEL_CMP = 0;
    localparam int unsigned SEL_ADD = 1;
    localparam int unsigned SEL_SUB = 2;
    localparam int unsigned SEL_DIV = 3;
    localparam int unsigned SEL_MUL = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SEL  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // True for opcodes that map onto an execution unit
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_MUL);
    endfunction

    // One-hot select for a legal opcode, all-zero otherwise
    function automatic logic [SEL_W-1:0] op_sel(input logic [OP_W-1:0] op);
        logic [SEL_W-1:0] sel;
        sel = '0;
        case (op)
            OP_CMP:  sel[SEL_CMP] = 1'b1;
            OP_ADD:  sel[SEL_ADD] = 1'b1;
            OP_SUB:  sel[SEL_SUB] = 1'b1;
            OP_DIV:  sel[SEL_DIV] = 1'b1;
            OP_MUL:  sel[SEL_MUL] = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// ---------------------------------------------------------------------------
// alu_lat_counter
// Down-counter timing the execution-unit latency.
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load load_val_i (has priority over decrement)
//   load_val_i   value to load (latency - 1)
//   dec_i        decrement by one; saturates at zero
//   zero_c       counter is zero (decoded from the register)
// ---------------------------------------------------------------------------
module alu_lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, decrement never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Sequences one ALU operation at a time: accepts a request, pulses start to
// the execution units, waits the per-op latency, drives the one-hot select
// into the registered result mux and holds a completion handshake.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op                     opcode, sampled only on the accept cycle
//   start                      one-cycle pulse in the first EXEC cycle
//   aCmp/aAdd/aSub/aDiv/aMul   one-hot result mux select
//   done_valid/done_ready      completion handshake
//   done_op, done_err          opcode of completed op, illegal-op flag
//   busy                       sequencer not idle
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned LAT_CMP = 1,
    parameter int unsigned LAT_ADD = 1,
    parameter int unsigned LAT_SUB = 1,
    parameter int unsigned LAT_DIV = 8,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    output logic            start,
    output logic            aCmp,
    output logic            aAdd,
    output logic            aSub,
    output logic            aDiv,
    output logic            aMul,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [OP_W-1:0] done_op,
    output logic            done_err,
    output logic            busy
);

    localparam int unsigned LAT_MAX = 1 << CNT_W;

    // Every latency must be representable as (LAT-1) in the counter
    if ((LAT_CMP < 1) || (LAT_CMP > LAT_MAX) ||
        (LAT_ADD < 1) || (LAT_ADD > LAT_MAX) ||
        (LAT_SUB < 1) || (LAT_SUB > LAT_MAX) ||
        (LAT_DIV < 1) || (LAT_DIV > LAT_MAX) ||
        (LAT_MUL < 1) || (LAT_MUL > LAT_MAX)) begin : g_lat_range_err
        $error("alu_op_sequencer: every LAT_* must lie in 1..2**CNT_W");
    end

    // Counter preload so that EXEC lasts exactly LAT(op) cycles
    function automatic logic [CNT_W-1:0] lat_load(input logic [OP_W-1:0] op);
        case (op)
            OP_CMP:  return CNT_W'(LAT_CMP - 1);
            OP_ADD:  return CNT_W'(LAT_ADD - 1);
            OP_SUB:  return CNT_W'(LAT_SUB - 1);
            OP_DIV:  return CNT_W'(LAT_DIV - 1);
            OP_MUL:  return CNT_W'(LAT_MUL - 1);
            default: return '0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             err_q, err_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic             req_ready_q, req_ready_d;
    logic             start_q, start_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_valid_q, done_valid_d;
    logic [OP_W-1:0]  done_op_q, done_op_d;
    logic             done_err_q, done_err_d;
    logic             busy_q, busy_d;

    alu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_c     (cnt_zero)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        err_d        = err_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // req_ready is high throughout IDLE, so valid alone accepts
                if (req_valid) begin
                    op_d = req_op;
                    if (op_legal(req_op)) begin
                        err_d        = 1'b0;
                        state_d      = ST_EXEC;
                        cnt_load     = 1'b1;
                        cnt_load_val = lat_load(req_op);
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    state_d = ST_SEL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SEL: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        start_d      = (state_q == ST_IDLE) && (state_d == ST_EXEC);
        done_valid_d = (state_d == ST_RESP);
        done_op_d    = (state_d == ST_RESP) ? op_d : '0;
        done_err_d   = (state_d == ST_RESP) && err_d;
        // Select held through SEL and RESP so the mux keeps reloading Y
        sel_d        = '0;
        if (((state_d == ST_SEL) || (state_d == ST_RESP)) && !err_d) begin
            sel_d = op_sel(op_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            start_q      <= 1'b0;
            sel_q        <= '0;
            done_valid_q <= 1'b0;
            done_op_q    <= '0;
            done_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            start_q      <= start_d;
            sel_q        <= sel_d;
            done_valid_q <= done_valid_d;
            done_op_q    <= done_op_d;
            done_err_q   <= done_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign start      = start_q;
    assign aCmp       = sel_q[SEL_CMP];
    assign aAdd       = sel_q[SEL_ADD];
    assign aSub       = sel_q[SEL_SUB];
    assign aDiv       = sel_q[SEL_DIV];
    assign aMul       = sel_q[SEL_MUL];
    assign done_valid = done_valid_q;
    assign done_op    = done_op_q;
    assign done_err   = done_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer with a small registered result mux
// model fed by the select lines. Observed outputs are packed as
// {req_ready, start, aMul, aDiv, aSub, aAdd, aCmp, done_valid, done_op,
//  done_err, busy} and compared against hand-built expected vectors.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam logic [15:0] R_CMP = 16'h0C0C;
    localparam logic [15:0] R_ADD = 16'hADD0;
    localparam logic [15:0] R_SUB = 16'h5B5B;
    localparam logic [15:0] P_DIV = 16'hD1D1;
    localparam logic [15:0] R_MUL = 16'h3A3A;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_CMP  = 5'b00001;
    localparam logic [4:0] S_ADD  = 5'b00010;
    localparam logic [4:0] S_SUB  = 5'b00100;
    localparam logic [4:0] S_DIV  = 5'b01000;
    localparam logic [4:0] S_MUL  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic       start;
    logic       aCmp, aAdd, aSub, aDiv, aMul;
    logic       done_valid;
    logic       done_ready = 1'b0;
    logic [2:0] done_op;
    logic       done_err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [15:0] y;
    logic [12:0] e;
    wire  [4:0]  sels = {aMul, aDiv, aSub, aAdd, aCmp};
    wire  [12:0] obs  = {req_ready, start, sels, done_valid, done_op, done_err, busy};

    alu_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .start      (start),
        .aCmp       (aCmp),
        .aAdd       (aAdd),
        .aSub       (aSub),
        .aDiv       (aDiv),
        .aMul       (aMul),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_op    (done_op),
        .done_err   (done_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Registered result mux: loads the selected unit output, 0 when none
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    y <= 16'h0;
        else if (aCmp) y <= R_CMP;
        else if (aAdd) y <= R_ADD;
        else if (aSub) y <= R_SUB;
        else if (aDiv) y <= P_DIV;
        else if (aMul) y <= R_MUL;
        else           y <= 16'h0;
    end

    // Select lines must never be more than one-hot
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(sels) > 1) begin
                failures++;
                $display("FAIL sel_onehot sels=%05b at %0t", sels, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic logic [12:0] mk(input logic rr, input logic st, input logic [4:0] s,
                                       input logic dv, input logic [2:0] dop,
                                       input logic derr, input logic bsy);
        return {rr, st, s, dv, dop, derr, bsy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge (the accept edge E0), then withdraw it
    task automatic accept(input logic [2:0] op);
        req_valid = 1'b1;
        req_op    = op;
        tick();
        req_valid = 1'b0;
        req_op    = 3'd7;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e || y !== 16'h0) begin
            failures++; $display("FAIL reset_state obs=%013b y=%h exp=%013b y=0", obs, y, e);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL reset_release obs=%013b exp=%013b", obs, e);
        end
    endtask

    task automatic test_add();
        done_ready = 1'b1;
        accept(3'd1);
        e = mk(0, 1, S_NONE, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL add_exec obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_ADD, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL add_sel obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_ADD, 1, 3'd1, 0, 1);
        checks++;
        if (obs !== e || y !== R_ADD) begin
            failures++; $display("FAIL add_resp obs=%013b y=%h exp=%013b y=%h", obs, y, e, R_ADD);
        end
        tick();
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL add_idle obs=%013b exp=%013b", obs, e); end
    endtask

    task automatic test_div();
        done_ready = 1'b1;
        accept(3'd3);
        e = mk(0, 1, S_NONE, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL div_exec0 obs=%013b exp=%013b", obs, e); end
        for (int k = 1; k < 8; k++) begin
            tick();
            e = mk(0, 0, S_NONE, 0, 3'd0, 0, 1);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL div_exec%0d obs=%013b exp=%013b", k, obs, e);
            end
        end
        tick();
        e = mk(0, 0, S_DIV, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL div_sel obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_DIV, 1, 3'd3, 0, 1);
        checks++;
        if (obs !== e || y !== P_DIV) begin
            failures++; $display("FAIL div_resp obs=%013b y=%h exp=%013b y=%h", obs, y, e, P_DIV);
        end
        tick();
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL div_idle obs=%013b exp=%013b", obs, e); end
    endtask

    task automatic test_mul_backpressure();
        done_ready = 1'b0;
        accept(3'd4);
        e = mk(0, 1, S_NONE, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL mul_exec0 obs=%013b exp=%013b", obs, e); end
        tick();
        tick();
        e = mk(0, 0, S_NONE, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL mul_exec2 obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_MUL, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL mul_sel obs=%013b exp=%013b", obs, e); end
        for (int k = 0; k < 5; k++) begin
            tick();
            e = mk(0, 0, S_MUL, 1, 3'd4, 0, 1);
            checks++;
            if (obs !== e || y !== R_MUL) begin
                failures++;
                $display("FAIL mul_hold%0d obs=%013b y=%h exp=%013b y=%h", k, obs, y, e, R_MUL);
            end
        end
        done_ready = 1'b1;
        tick();
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL mul_idle obs=%013b exp=%013b", obs, e); end
    endtask

    task automatic test_illegal();
        done_ready = 1'b0;
        accept(3'd6);
        e = mk(0, 0, S_NONE, 1, 3'd6, 1, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL ill_resp obs=%013b exp=%013b", obs, e); end
        tick();
        checks++;
        if (obs !== e || y !== 16'h0) begin
            failures++; $display("FAIL ill_hold obs=%013b y=%h exp=%013b y=0", obs, y, e);
        end
        done_ready = 1'b1;
        tick();
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL ill_idle obs=%013b exp=%013b", obs, e); end
    endtask

    task automatic test_reset_mid_exec();
        int  n;
        logic seen;
        done_ready = 1'b1;
        accept(3'd3);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e || y !== 16'h0) begin
            failures++; $display("FAIL rstmid_outs obs=%013b y=%h exp=%013b y=0", obs, y, e);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_ghost_done seen=%0b exp=0", seen); end
        accept(3'd0);
        n = 0;
        while (done_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2) begin failures++; $display("FAIL rstmid_cmp_latency cycles=%0d exp=2", n); end
        e = mk(0, 0, S_CMP, 1, 3'd0, 0, 1);
        checks++;
        if (obs !== e || y !== R_CMP) begin
            failures++; $display("FAIL rstmid_cmp_resp obs=%013b y=%h exp=%013b y=%h", obs, y, e, R_CMP);
        end
        tick();
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL rstmid_idle obs=%013b exp=%013b", obs, e); end
    endtask

    task automatic test_back_to_back();
        done_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = 3'd0;
        tick();
        req_op = 3'd2;
        e = mk(0, 1, S_NONE, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_cmp_exec obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_CMP, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_cmp_sel obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_CMP, 1, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_cmp_resp obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_no_accept obs=%013b exp=%013b", obs, e); end
        tick();
        req_valid = 1'b0;
        req_op    = 3'd7;
        e = mk(0, 1, S_NONE, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_sub_accept obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_SUB, 0, 3'd0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_sub_sel obs=%013b exp=%013b", obs, e); end
        tick();
        e = mk(0, 0, S_SUB, 1, 3'd2, 0, 1);
        checks++;
        if (obs !== e || y !== R_SUB) begin
            failures++; $display("FAIL b2b_sub_resp obs=%013b y=%h exp=%013b y=%h", obs, y, e, R_SUB);
        end
        tick();
        e = mk(1, 0, S_NONE, 0, 3'd0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_idle obs=%013b exp=%013b", obs, e); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_mul_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_back_to_back();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
